wb_arbiter: RTL and testbench



---
 rtl/wb_arbiter.sv | 173 +++++++++++++++++
 tb/tb_wb_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Two-controller round-robin arbiter for the pipelined Wishbone B4 peripheral bus.
// A per-cycle watchdog aborts transfers that never see an ack.
package common_pkg;
  localparam int unsigned WB_ADDR_WIDTH = 8;
  localparam int unsigned DATA_WIDTH    = 8;

  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    data;
    logic                     we;
    logic                     cycle;
    logic                     strobe;
  } wb_req_t;
endpackage

module wb_arbiter
  import common_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                     wb_clock_i,
  input  logic                     wb_reset_i,
  input  logic [WB_ADDR_WIDTH-1:0] c0_addr_i,
  input  logic [DATA_WIDTH-1:0]    c0_data_i,
  input  logic                     c0_we_i,
  input  logic                     c0_cycle_i,
  input  logic                     c0_strobe_i,
  output logic [DATA_WIDTH-1:0]    c0_data_o,
  output logic                     c0_stall_o,
  output logic                     c0_ack_o,
  output logic                     c0_err_o,
  input  logic [WB_ADDR_WIDTH-1:0] c1_addr_i,
  input  logic [DATA_WIDTH-1:0]    c1_data_i,
  input  logic                     c1_we_i,
  input  logic                     c1_cycle_i,
  input  logic                     c1_strobe_i,
  output logic [DATA_WIDTH-1:0]    c1_data_o,
  output logic                     c1_stall_o,
  output logic                     c1_ack_o,
  output logic                     c1_err_o,
  output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0]    wb_data_o,
  output logic                     wb_we_o,
  output logic                     wb_cycle_o,
  output logic                     wb_strobe_o,
  input  logic [DATA_WIDTH-1:0]    wb_data_i,
  input  logic                     wb_stall_i,
  input  logic                     wb_ack_i,
  output logic [1:0]               grant_o
);
  localparam int unsigned WD_WIDTH  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned OUT_WIDTH = 4;
  localparam logic [WD_WIDTH-1:0]  WD_LIMIT = WD_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [OUT_WIDTH-1:0] OUT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic                 owner, owner_nxt;
  logic                 last_owner, last_owner_nxt;
  logic [WD_WIDTH-1:0]  wd_cnt, wd_cnt_nxt;
  logic [OUT_WIDTH-1:0] outstanding, outstanding_nxt;
  logic                 err_q, err_nxt;
  wb_req_t              c0_req, c1_req, own_req, bus;
  logic [1:0]           stall_v, ack_v;
  logic                 accepted, ack_taken;

  assign c0_req  = {c0_addr_i, c0_data_i, c0_we_i, c0_cycle_i, c0_strobe_i};
  assign c1_req  = {c1_addr_i, c1_data_i, c1_we_i, c1_cycle_i, c1_strobe_i};
  assign own_req = owner ? c1_req : c0_req;

  always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
    if (wb_reset_i) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_owner  <= 1'b1;
      wd_cnt      <= '0;
      outstanding <= '0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      last_owner  <= last_owner_nxt;
      wd_cnt      <= wd_cnt_nxt;
      outstanding <= outstanding_nxt;
      err_q       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    owner_nxt       = owner;
    last_owner_nxt  = last_owner;
    wd_cnt_nxt      = wd_cnt;
    outstanding_nxt = outstanding;
    err_nxt         = 1'b0;
    bus             = '0;
    stall_v         = 2'b11;
    ack_v           = 2'b00;
    accepted        = 1'b0;
    ack_taken       = 1'b0;
    case (state)
      IDLE: begin
        wd_cnt_nxt      = '0;
        outstanding_nxt = '0;
        // Tie goes to whoever did not own the bus last.
        if (c0_req.cycle && c1_req.cycle) begin
          owner_nxt = ~last_owner;
          state_nxt = GRANT;
        end else if (c0_req.cycle) begin
          owner_nxt = 1'b0;
          state_nxt = GRANT;
        end else if (c1_req.cycle) begin
          owner_nxt = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        bus            = own_req;
        bus.strobe     = own_req.strobe & own_req.cycle;
        stall_v[owner] = wb_stall_i;
        ack_v[owner]   = wb_ack_i;
        accepted       = bus.strobe & ~wb_stall_i;
        ack_taken      = wb_ack_i & (outstanding != '0);
        if (accepted && !ack_taken && outstanding != OUT_MAX) begin
          outstanding_nxt = outstanding + OUT_WIDTH'(1);
        end else if (!accepted && ack_taken) begin
          outstanding_nxt = outstanding - OUT_WIDTH'(1);
        end
        // Watchdog runs only while a transfer is being requested or awaited.
        if (wb_ack_i) begin
          wd_cnt_nxt = '0;
        end else if ((bus.strobe || outstanding != '0) && wd_cnt != WD_LIMIT) begin
          wd_cnt_nxt = wd_cnt + WD_WIDTH'(1);
        end
        if (!own_req.cycle) begin
          last_owner_nxt = owner;
          state_nxt      = IDLE;
        end else if (wd_cnt == WD_LIMIT) begin
          err_nxt   = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!own_req.cycle) begin
          last_owner_nxt = owner;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wb_addr_o   = bus.addr;
  assign wb_data_o   = bus.data;
  assign wb_we_o     = bus.we;
  assign wb_cycle_o  = bus.cycle;
  assign wb_strobe_o = bus.strobe;

  assign c0_data_o  = wb_data_i;
  assign c1_data_o  = wb_data_i;
  assign c0_stall_o = stall_v[0];
  assign c1_stall_o = stall_v[1];
  assign c0_ack_o   = ack_v[0];
  assign c1_ack_o   = ack_v[1];
  assign c0_err_o   = err_q & ~owner;
  assign c1_err_o   = err_q & owner;
  assign grant_o    = (state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and randomized bench for wb_arbiter, checked every cycle against a
// cycle-level behavioural model of the arbitration and watchdog rules.
module tb_wb_arbiter;
  import common_pkg::*;

  localparam int unsigned AW = WB_ADDR_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdat [2];
  logic          we   [2];
  logic          cyc  [2];
  logic          stb  [2];
  logic [DW-1:0] rdat [2];
  logic          stall[2];
  logic          ack  [2];
  logic          err  [2];
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_wdat, wb_rdat;
  logic          wb_we, wb_cyc, wb_stb, wb_stall, wb_ack;
  logic [1:0]    grant;

  int checks = 0;
  int errors = 0;

  // Model: holder -1 means the bus is free.
  int m_holder, m_last, m_wd, m_pend;
  bit m_drain, m_err;

  always #5 clk = ~clk;

  wb_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .wb_clock_i (clk),      .wb_reset_i (rst),
    .c0_addr_i  (addr[0]),  .c0_data_i  (wdat[0]), .c0_we_i (we[0]),
    .c0_cycle_i (cyc[0]),   .c0_strobe_i(stb[0]),
    .c0_data_o  (rdat[0]),  .c0_stall_o (stall[0]), .c0_ack_o(ack[0]), .c0_err_o(err[0]),
    .c1_addr_i  (addr[1]),  .c1_data_i  (wdat[1]), .c1_we_i (we[1]),
    .c1_cycle_i (cyc[1]),   .c1_strobe_i(stb[1]),
    .c1_data_o  (rdat[1]),  .c1_stall_o (stall[1]), .c1_ack_o(ack[1]), .c1_err_o(err[1]),
    .wb_addr_o  (wb_addr),  .wb_data_o  (wb_wdat), .wb_we_o (wb_we),
    .wb_cycle_o (wb_cyc),   .wb_strobe_o(wb_stb),
    .wb_data_i  (wb_rdat),  .wb_stall_i (wb_stall), .wb_ack_i(wb_ack),
    .grant_o    (grant)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_holder = -1;
    m_last   = 1;
    m_wd     = 0;
    m_pend   = 0;
    m_drain  = 1'b0;
    m_err    = 1'b0;
  endtask

  task automatic idle_inputs();
    for (int n = 0; n < 2; n++) begin
      addr[n] = '0; wdat[n] = '0; we[n] = 1'b0; cyc[n] = 1'b0; stb[n] = 1'b0;
    end
    wb_rdat = '0; wb_stall = 1'b0; wb_ack = 1'b0;
  endtask

  task automatic check_outputs();
    bit         live;
    int         h;
    logic [1:0] exp_grant;
    h         = (m_holder < 0) ? 0 : m_holder;
    live      = (m_holder >= 0) && !m_drain;
    exp_grant = (m_holder < 0) ? 2'b00 : ((m_holder == 0) ? 2'b01 : 2'b10);
    chk("grant", 64'(grant), 64'(exp_grant));
    chk("wb_cycle", 64'(wb_cyc), 64'(live && cyc[h]));
    chk("wb_strobe", 64'(wb_stb), 64'(live && cyc[h] && stb[h]));
    chk("wb_addr", 64'(wb_addr), live ? 64'(addr[h]) : 64'd0);
    chk("wb_data", 64'(wb_wdat), live ? 64'(wdat[h]) : 64'd0);
    chk("wb_we", 64'(wb_we), 64'(live && we[h]));
    for (int n = 0; n < 2; n++) begin
      bit mine;
      mine = live && (h == n);
      chk($sformatf("c%0d_stall", n), 64'(stall[n]), 64'(mine ? wb_stall : 1'b1));
      chk($sformatf("c%0d_ack", n), 64'(ack[n]), 64'(mine && wb_ack));
      chk($sformatf("c%0d_err", n), 64'(err[n]), 64'(m_err && m_holder == n));
      chk($sformatf("c%0d_data", n), 64'(rdat[n]), 64'(wb_rdat));
    end
  endtask

  task automatic model_clock();
    bit req, busy, dec;
    if (rst) begin
      model_reset();
      return;
    end
    m_err = 1'b0;
    if (m_holder < 0) begin
      m_wd = 0; m_pend = 0; m_drain = 1'b0;
      if (cyc[0] && cyc[1]) m_holder = 1 - m_last;
      else if (cyc[0])      m_holder = 0;
      else if (cyc[1])      m_holder = 1;
    end else if (!cyc[m_holder]) begin
      m_last   = m_holder;
      m_holder = -1;
    end else if (!m_drain && m_wd == TO) begin
      m_drain = 1'b1;
      m_err   = 1'b1;
    end else if (!m_drain) begin
      req  = stb[m_holder];
      busy = req || (m_pend > 0);
      dec  = wb_ack && (m_pend > 0);
      m_pend = m_pend + ((req && !wb_stall) ? 1 : 0) - (dec ? 1 : 0);
      if (m_pend > 15) m_pend = 15;
      if (wb_ack)     m_wd = 0;
      else if (busy)  m_wd = (m_wd + 1 > TO) ? TO : m_wd + 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  int         n, o, acks, errs;
  bit         dead;
  logic [3:0] rr_exp;
  logic [9:0] stb_pat, stall_pat, ack_pat;
  logic [DW-1:0] rd_val;

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    tick();
    tick();
    chk("reset_grant", 64'(grant), 64'd0);
    chk("reset_c1_stall", 64'(stall[1]), 64'd1);
    chk("reset_wb_cycle", 64'(wb_cyc), 64'd0);
    rst = 1'b0;
    tick();

    // c0 single read of address 0
    cyc[0] = 1'b1; stb[0] = 1'b1; addr[0] = '0; we[0] = 1'b0;
    #1 chk("read_grant_early", 64'(grant), 64'd0);
    tick();
    chk("read_grant_latency", 64'(grant), 64'h1);
    chk("read_wb_cycle", 64'(wb_cyc), 64'd1);
    chk("read_c0_stall", 64'(stall[0]), 64'd0);
    tick();
    rd_val = DW'(8'hA5);
    stb[0] = 1'b0; wb_ack = 1'b1; wb_rdat = rd_val;
    #1;
    chk("read_c0_ack", 64'(ack[0]), 64'd1);
    chk("read_c0_data", 64'(rdat[0]), 64'(rd_val));
    chk("read_c1_ack", 64'(ack[1]), 64'd0);
    tick();
    wb_ack = 1'b0; cyc[0] = 1'b0;
    tick();
    tick();

    // Reset asserted during an active c0 cycle acts without a clock edge
    cyc[0] = 1'b1; stb[0] = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_mid_wb_cycle", 64'(wb_cyc), 64'd0);
    chk("rst_mid_grant", 64'(grant), 64'd0);
    chk("rst_mid_c0_stall", 64'(stall[0]), 64'd1);
    tick();
    cyc[0] = 1'b0; stb[0] = 1'b0; rst = 1'b0;
    tick();

    // Simultaneous request right after reset
    cyc[0] = 1'b1; cyc[1] = 1'b1; stb[0] = 1'b1;
    tick();
    chk("sim_grant_c0", 64'(grant), 64'h1);
    chk("sim_c1_stall", 64'(stall[1]), 64'd1);
    tick();
    stb[0] = 1'b0; wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0; cyc[0] = 1'b0;
    tick();
    chk("sim_release_idle", 64'(grant), 64'd0);
    tick();
    chk("sim_grant_c1", 64'(grant), 64'h2);
    chk("sim_c1_stall_granted", 64'(stall[1]), 64'd0);
    cyc[1] = 1'b0;
    tick();
    tick();

    // Round-robin over four back-to-back transactions
    rr_exp = 4'b1010;
    cyc[0] = 1'b1; cyc[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (grant == 2'b00 && n < 8) begin
        tick();
        n++;
      end
      chk($sformatf("rr_wait_%0d", k), 64'(n < 8), 64'd1);
      o = (grant == 2'b10) ? 1 : 0;
      chk($sformatf("rr_owner_%0d", k), 64'(o), 64'(rr_exp[k]));
      stb[o] = 1'b1;
      tick();
      stb[o] = 1'b0; wb_ack = 1'b1;
      tick();
      wb_ack = 1'b0; cyc[o] = 1'b0;
      tick();
      if (k < 3) cyc[o] = 1'b1;
    end
    cyc[0] = 1'b0; cyc[1] = 1'b0;
    tick();
    tick();

    // Watchdog timeout on c1 with a peripheral that never acks
    cyc[1] = 1'b1; stb[1] = 1'b1;
    tick();
    chk("to_grant_c1", 64'(grant), 64'h2);
    tick();
    stb[1] = 1'b0;
    n = 1;
    while (err[1] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("to_err_latency", 64'(n), 64'd16);
    chk("to_wb_cycle_drop", 64'(wb_cyc), 64'd0);
    chk("to_no_ack_with_err", 64'(ack[1]), 64'd0);
    tick();
    chk("to_err_one_cycle", 64'(err[1]), 64'd0);
    wb_ack = 1'b1;
    #1 chk("to_late_ack_dropped", 64'(ack[1]), 64'd0);
    tick();
    wb_ack = 1'b0; cyc[0] = 1'b1; cyc[1] = 1'b0;
    tick();
    chk("to_release_idle", 64'(grant), 64'd0);
    tick();
    chk("to_grant_c0", 64'(grant), 64'h1);
    cyc[0] = 1'b0;
    tick();
    tick();

    // Pipelined burst: three strobes, one stalled cycle, late acks
    stb_pat   = 10'b0000011111;
    stall_pat = 10'b0000000100;
    ack_pat   = 10'b1101000000;
    acks = 0; errs = 0;
    cyc[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      stb[0] = stb_pat[i]; wb_stall = stall_pat[i]; wb_ack = ack_pat[i];
      #1;
      if (ack[0] === 1'b1) acks++;
      if (err[0] === 1'b1) errs++;
      tick();
    end
    chk("burst_ack_count", 64'(acks), 64'd3);
    chk("burst_no_err", 64'(errs), 64'd0);
    idle_inputs();
    tick();
    tick();

    // Randomized traffic, including dead-peripheral stretches and resets
    dead = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (cyc[c]) begin
          if ($urandom_range(0, 15) == 0) cyc[c] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          cyc[c] = 1'b1;
        end
        stb[c]  = cyc[c] && ($urandom_range(0, 1) == 1);
        addr[c] = AW'($urandom);
        wdat[c] = DW'($urandom);
        we[c]   = ($urandom_range(0, 1) == 1);
      end
      if ($urandom_range(0, 63) == 0) dead = !dead;
      wb_stall = ($urandom_range(0, 3) == 0);
      wb_ack   = !dead && ($urandom_range(0, 2) == 0);
      wb_rdat  = DW'($urandom);
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
